porta_ocupacao: RTL and testbench

- Parametrised successor of the single-door controller: one door with entry and exit requests, a passage sensor, and an occupancy counter with a capacity limit.
- Adds an open-door timeout that raises an alarm, and a capacity-full denial.
- Drives the board's HEX0 digit, the green LED, the red LED and the buzzer LED.
- Sits between the board switches/key and the display and LED outputs.

---
 rtl/porta_ocupacao.sv | 148 ++++++++++++++
 tb/tb_porta_ocupacao.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/porta_ocupacao.sv
// porta_ocupacao: single-door access controller with occupancy counting,
// capacity-full denial and an open-door timeout alarm, driving HEX0 and LEDs.
module porta_ocupacao #(
  parameter int MAX_OCUP = 15,
  parameter int CNT_W    = 4,
  parameter int T_OPEN   = 1000,
  parameter int T_ALARM  = 500,
  parameter int TMR_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       SW,
  input  logic             KEY,
  output logic [0:6]       HEX0,
  output logic             LEDG,
  output logic [1:0]       LEDR,
  output logic [CNT_W-1:0] OCUP,
  output logic             FULL
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ENT_OPEN = 3'd1;
  localparam logic [2:0] SAI_OPEN = 3'd2;
  localparam logic [2:0] CONFLITO = 3'd3;
  localparam logic [2:0] LOTADO   = 3'd4;
  localparam logic [2:0] PASSOU   = 3'd5;
  localparam logic [2:0] ALARME   = 3'd6;

  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_OCUP);
  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(T_OPEN - 1);
  localparam logic [TMR_W-1:0] ALARM_LAST = TMR_W'(T_ALARM - 1);
  localparam logic [TMR_W-1:0] ALARM_SAT  = TMR_W'(T_ALARM);

  localparam logic [0:6] SEG_E   = 7'b0110000;
  localparam logic [0:6] SEG_S   = 7'b0100100;
  localparam logic [0:6] SEG_F   = 7'b0111000;
  localparam logic [0:6] SEG_A   = 7'b0001000;
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  logic             s1, s2, s3;
  logic             pass;
  logic [2:0]       state, nextState;
  logic [TMR_W-1:0] timer, nextTimer;
  logic [CNT_W-1:0] nextOcup;
  logic [0:6]       nextHex;
  logic             nextLedg;
  logic [1:0]       nextLedr;

  // Synchronise the asynchronous passage sensor and keep one extra delayed copy for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= KEY;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pass = s3 & ~s2;

  // Next-state, timer and occupancy decision for the door sequence
  always_comb begin
    nextState = state;
    nextTimer = timer;
    nextOcup  = OCUP;
    case (state)
      IDLE: begin
        case (SW)
          2'b10: nextState = (OCUP < MAX_C) ? ENT_OPEN : LOTADO;
          2'b01: if (OCUP != '0) nextState = SAI_OPEN;
          2'b11: nextState = CONFLITO;
          default: nextState = IDLE;
        endcase
        if (nextState != IDLE) nextTimer = '0;
      end
      ENT_OPEN, SAI_OPEN: begin
        nextTimer = timer + 1'b1;
        if (pass) begin
          nextState = PASSOU;
          if (state == ENT_OPEN) begin
            if (OCUP != MAX_C) nextOcup = OCUP + 1'b1;
          end else begin
            if (OCUP != '0) nextOcup = OCUP - 1'b1;
          end
        end else if (timer == OPEN_LAST) begin
          nextState = ALARME;
          nextTimer = '0;
        end
      end
      ALARME: begin
        if (timer < ALARM_SAT) nextTimer = timer + 1'b1;
        if ((timer >= ALARM_LAST) && (SW == 2'b00)) nextState = IDLE;
      end
      CONFLITO: begin
        if (SW == 2'b00) begin
          nextState = IDLE;
        end else if ((SW == 2'b01) && (OCUP != '0)) begin
          nextState = SAI_OPEN;
          nextTimer = '0;
        end
      end
      LOTADO, PASSOU: begin
        if (SW == 2'b00) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Display and LED patterns decoded from the upcoming state so they line up with it
  always_comb begin
    nextHex  = SEG_OFF;
    nextLedg = 1'b0;
    nextLedr = 2'b00;
    case (nextState)
      ENT_OPEN: begin nextHex = SEG_E; nextLedg = 1'b1; end
      SAI_OPEN: begin nextHex = SEG_S; nextLedg = 1'b1; end
      LOTADO:   begin nextHex = SEG_F; nextLedr = 2'b01; end
      ALARME:   begin nextHex = SEG_A; nextLedr = 2'b11; end
      CONFLITO, PASSOU: nextLedr = 2'b01;
      default: nextHex = SEG_OFF;
    endcase
  end

  // State, timer, occupancy and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      OCUP  <= '0;
      HEX0  <= SEG_OFF;
      LEDG  <= 1'b0;
      LEDR  <= 2'b00;
    end else begin
      state <= nextState;
      timer <= nextTimer;
      OCUP  <= nextOcup;
      HEX0  <= nextHex;
      LEDG  <= nextLedg;
      LEDR  <= nextLedr;
    end
  end

  assign FULL = (OCUP == MAX_C);

endmodule

// File: tb/tb_porta_ocupacao.sv
// tb_porta_ocupacao: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the door controller.
module tb_porta_ocupacao;

  localparam int MAX_OCUP = 3;
  localparam int CNT_W    = 4;
  localparam int T_OPEN   = 20;
  localparam int T_ALARM  = 12;
  localparam int TMR_W    = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       SW;
  logic             KEY;
  logic [0:6]       HEX0;
  logic             LEDG;
  logic [1:0]       LEDR;
  logic [CNT_W-1:0] OCUP;
  logic             FULL;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  typedef enum {M_IDLE, M_ENT, M_SAI, M_CONF, M_LOT, M_PASS, M_ALARM} mstate_t;
  mstate_t mState = M_IDLE;
  int  mOcup = 0;
  int  mTime = 0;
  bit  k1 = 1'b1, k2 = 1'b1, k3 = 1'b1;

  porta_ocupacao #(
    .MAX_OCUP(MAX_OCUP), .CNT_W(CNT_W), .T_OPEN(T_OPEN),
    .T_ALARM(T_ALARM), .TMR_W(TMR_W)
  ) dut (
    .CLK(CLK), .RST(RST), .SW(SW), .KEY(KEY),
    .HEX0(HEX0), .LEDG(LEDG), .LEDR(LEDR), .OCUP(OCUP), .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, observed, expected);
    end
  endtask

  // One clock edge of the reference: a passage is seen when KEY sampled
  // three edges ago was high and two edges ago was low.
  task automatic applyStimulus();
    bit passNow;
    passNow = k3 & ~k2;
    if (RST) begin
      mState = M_IDLE; mOcup = 0; mTime = 0;
      k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
      return;
    end
    case (mState)
      M_IDLE: begin
        mTime = 0;
        if (SW == 2'b10) mState = (mOcup < MAX_OCUP) ? M_ENT : M_LOT;
        else if (SW == 2'b01 && mOcup > 0) mState = M_SAI;
        else if (SW == 2'b11) mState = M_CONF;
      end
      M_ENT, M_SAI: begin
        if (passNow) begin
          mOcup = (mState == M_ENT) ? mOcup + 1 : mOcup - 1;
          mState = M_PASS;
        end else if (mTime == T_OPEN - 1) begin
          mState = M_ALARM;
          mTime = 0;
        end else begin
          mTime++;
        end
      end
      M_ALARM: begin
        if (mTime >= T_ALARM - 1 && SW == 2'b00) mState = M_IDLE;
        else mTime++;
      end
      M_CONF: begin
        if (SW == 2'b00) mState = M_IDLE;
        else if (SW == 2'b01 && mOcup > 0) begin mState = M_SAI; mTime = 0; end
      end
      default: if (SW == 2'b00) mState = M_IDLE;
    endcase
    k3 = k2; k2 = k1; k1 = KEY;
  endtask

  task automatic stepCycle();
    int expHex, expLedg, expLedr;
    @(posedge CLK);
    applyStimulus();
    cycle++;
    #1;
    expHex = 7'b1111111; expLedg = 0; expLedr = 0;
    case (mState)
      M_ENT:   begin expHex = 7'b0110000; expLedg = 1; end
      M_SAI:   begin expHex = 7'b0100100; expLedg = 1; end
      M_LOT:   begin expHex = 7'b0111000; expLedr = 1; end
      M_ALARM: begin expHex = 7'b0001000; expLedr = 3; end
      M_CONF, M_PASS: expLedr = 1;
      default: expHex = 7'b1111111;
    endcase
    checkOutput("hex0", int'(HEX0), expHex);
    checkOutput("ledg", int'(LEDG), expLedg);
    checkOutput("ledr", int'(LEDR), expLedr);
    checkOutput("ocup", int'(OCUP), mOcup);
    checkOutput("full", int'(FULL), (mOcup == MAX_OCUP) ? 1 : 0);
  endtask

  task automatic doPassage(input logic [1:0] dir);
    SW = dir;
    stepCycle();
    SW = 2'b00;
    KEY = 1'b0;
    repeat (5) stepCycle();
    KEY = 1'b1;
    repeat (3) stepCycle();
  endtask

  initial begin
    int r, dur;
    bit keyActive;
    RST = 1'b1; SW = 2'b00; KEY = 1'b1;
    repeat (2) stepCycle();
    RST = 1'b0;
    repeat (2) stepCycle();

    // empty room: exit request ignored, conflict, exit request held in conflict
    SW = 2'b01; repeat (3) stepCycle();
    SW = 2'b11; repeat (2) stepCycle();
    SW = 2'b01; repeat (3) stepCycle();
    SW = 2'b00; repeat (2) stepCycle();

    // normal entry
    doPassage(2'b10);

    // open-door timeout; request released early in the alarm
    SW = 2'b10; stepCycle();
    SW = 2'b00; repeat (T_OPEN + T_ALARM + 4) stepCycle();

    // passage landing on the timeout edge
    SW = 2'b10; stepCycle();
    SW = 2'b00; repeat (T_OPEN - 3) stepCycle();
    KEY = 1'b0; repeat (4) stepCycle();
    checkOutput("pass_at_expiry_ledr1", int'(LEDR[1]), 0);
    KEY = 1'b1; repeat (3) stepCycle();

    // fill to capacity, denied entry, then one exit
    doPassage(2'b10);
    SW = 2'b10; repeat (3) stepCycle();
    SW = 2'b00; stepCycle();
    doPassage(2'b01);

    // reset while open with KEY held low
    SW = 2'b10; stepCycle();
    KEY = 1'b0; stepCycle();
    RST = 1'b1; stepCycle();
    RST = 1'b0; SW = 2'b00; repeat (6) stepCycle();
    KEY = 1'b1; repeat (3) stepCycle();

    // randomized traffic
    repeat (150) begin
      r = $urandom_range(0, 9);
      SW = (r < 4) ? 2'b10 : (r < 7) ? 2'b00 : (r < 9) ? 2'b01 : 2'b11;
      dur = $urandom_range(1, 30);
      keyActive = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < dur; i++) begin
        if (keyActive && $urandom_range(0, 5) == 0) KEY = ~KEY;
        RST = ($urandom_range(0, 299) == 0);
        stepCycle();
      end
      RST = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
